// File: rtl/tcb_lib_register_request_if.sv
// TCB request/response bundle used on both the manager and subordinate side of the register slice.
interface tcb_lib_register_request_if #(
    parameter int unsigned ADR = 32,
    parameter int unsigned DAT = 32,
    parameter int unsigned BEN = DAT/8
);
    logic           vld;
    logic           rdy;
    logic           wen;
    logic [ADR-1:0] adr;
    logic [BEN-1:0] ben;
    logic [DAT-1:0] wdt;
    logic           rsp;
    logic [DAT-1:0] rdt;
    logic           err;

    modport master (
        output vld, wen, adr, ben, wdt,
        input  rdy, rsp, rdt, err
    );

    modport slave (
        input  vld, wen, adr, ben, wdt,
        output rdy, rsp, rdt, err
    );
endinterface

// File: rtl/tcb_lib_register_request.sv
// TCB request-path register slice with DLY-deep response tracking.
// Define TCB_LIB_REGISTER_REQUEST_SKID_EN for the 2-entry skid buffer with registered man_rdy.
module tcb_lib_register_request #(
    parameter int unsigned ADR = 32,
    parameter int unsigned DAT = 32,
    parameter int unsigned BEN = DAT/8,
    parameter int unsigned DLY = 1
)(
    input  logic                        clk,
    input  logic                        rst,
    tcb_lib_register_request_if.slave   man,
    tcb_lib_register_request_if.master  sub
);

    typedef struct packed {
        logic           wen;
        logic [ADR-1:0] adr;
        logic [BEN-1:0] ben;
        logic [DAT-1:0] wdt;
    } req_t;

    req_t man_req;
    req_t out_q;
    logic man_rdy;
    logic man_trn;
    logic sub_trn;
    logic ld_out;
    logic rsp;
    logic rsp_wen;

    assign man_req = {man.wen, man.adr, man.ben, man.wdt};
    assign man_trn = man.vld & man_rdy;
    assign sub_trn = sub.vld & sub.rdy;
    assign man.rdy = man_rdy;

`ifdef TCB_LIB_REGISTER_REQUEST_SKID_EN

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q;
    state_t state_d;
    req_t   skd_q;
    logic   ld_skd;
    logic   mv_skd;
    logic   rdy_q;

    // rdy_q is precomputed from the next state so man_rdy never sees sub_rdy combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        ld_out  = 1'b0;
        ld_skd  = 1'b0;
        mv_skd  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (man_trn) begin
                    state_d = ONE;
                    ld_out  = 1'b1;
                end
            end
            ONE: begin
                if (man_trn && sub_trn) begin
                    ld_out = 1'b1;
                end else if (man_trn) begin
                    state_d = TWO;
                    ld_skd  = 1'b1;
                end else if (sub_trn) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (sub_trn) begin
                    state_d = ONE;
                    mv_skd  = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            skd_q <= '0;
        end else begin
            if (ld_out) begin
                out_q <= man_req;
            end else if (mv_skd) begin
                out_q <= skd_q;
            end
            if (ld_skd) begin
                skd_q <= man_req;
            end
        end
    end

    assign man_rdy = rdy_q;

`else

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_out  = 1'b0;
        if (man_trn) begin
            state_d = FULL;
            ld_out  = 1'b1;
        end else if (sub_trn) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else if (ld_out) begin
            out_q <= man_req;
        end
    end

    assign man_rdy = (state_q != FULL) | sub.rdy;

`endif

    assign sub.vld = (state_q != EMPTY);
    assign sub.wen = out_q.wen;
    assign sub.adr = out_q.adr;
    assign sub.ben = out_q.ben;
    assign sub.wdt = out_q.wdt;

    // every stage shifts each cycle, so the pipeline cannot overflow
    generate
        if (DLY == 0) begin : g_rsp_comb
            assign rsp     = sub_trn;
            assign rsp_wen = out_q.wen;
        end else begin : g_rsp_pipe
            logic [DLY:1] rsp_pipe;
            logic [DLY:1] wen_pipe;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rsp_pipe <= '0;
                    wen_pipe <= '0;
                end else begin
                    rsp_pipe[1] <= sub_trn;
                    wen_pipe[1] <= out_q.wen;
                    for (int i = 2; i <= DLY; i++) begin
                        rsp_pipe[i] <= rsp_pipe[i-1];
                        wen_pipe[i] <= wen_pipe[i-1];
                    end
                end
            end

            assign rsp     = rsp_pipe[DLY];
            assign rsp_wen = wen_pipe[DLY];
        end
    endgenerate

    assign man.rsp = rsp;
    assign man.rdt = (rsp && !rsp_wen) ? sub.rdt : '0;
    assign man.err = sub.err & rsp;

    // the subordinate side carries no response strobe
    logic unused_sub_rsp;
    assign unused_sub_rsp = sub.rsp;

endmodule

// File: tb/tb_tcb_lib_register_request.sv
// Self-checking bench for tcb_lib_register_request: one DLY=0 and one DLY=1 instance share the manager stimulus.
module tb_tcb_lib_register_request;

    localparam int ADR = 32;
    localparam int DAT = 32;
    localparam int BEN = 4;

    typedef struct packed {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
    } req_t;

    typedef struct {
        req_t r;
        bit   lat;
        int   cyc;
    } req_ent_t;

    typedef struct {
        logic [31:0] rdt;
        logic        err;
        bit          lat;
        int          cyc;
    } rsp_ent_t;

    typedef struct {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
        logic [31:0] rdt;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        m_vld = 1'b0;
    logic        m_wen = 1'b0;
    logic [31:0] m_adr = '0;
    logic [3:0]  m_ben = '0;
    logic [31:0] m_wdt = '0;
    logic        s_rdy = 1'b1;
    logic [31:0] e_rdt = '0;
    logic        e_err = 1'b0;
    bit          lat_chk = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void check_output(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    // subordinate memory model: fixed words for the directed addresses, a pattern elsewhere
    function automatic logic [31:0] sub_data(logic [31:0] a);
        case (a)
            32'h20:  return 32'hDEADBEEF;
            32'h04:  return 32'h12345678;
            default: return a ^ 32'h5A5A0000;
        endcase
    endfunction

    function automatic logic sub_fault(logic [31:0] a);
        return (a == 32'h10);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        tcb_lib_register_request_if #(.ADR(ADR), .DAT(DAT), .BEN(BEN)) mi ();
        tcb_lib_register_request_if #(.ADR(ADR), .DAT(DAT), .BEN(BEN)) si ();

        assign mi.vld = m_vld;
        assign mi.wen = m_wen;
        assign mi.adr = m_adr;
        assign mi.ben = m_ben;
        assign mi.wdt = m_wdt;
        assign si.rdy = s_rdy;
        assign si.rsp = 1'b0;

        tcb_lib_register_request #(.ADR(ADR), .DAT(DAT), .BEN(BEN), .DLY(g)) dut (
            .clk (clk),
            .rst (rst),
            .man (mi),
            .sub (si)
        );

        // read data outside a response window is random so masking is exercised
        if (g == 0) begin : comb_sub
            logic [31:0] garbage;
            logic        garb_err;
            always @(posedge clk) begin
                garbage  <= $urandom;
                garb_err <= 1'($urandom_range(0, 1));
            end
            assign si.rdt = (si.vld && si.rdy) ? sub_data(si.adr) : garbage;
            assign si.err = (si.vld && si.rdy) ? sub_fault(si.adr) : garb_err;
        end else begin : reg_sub
            always @(posedge clk) begin
                if (si.vld && si.rdy) begin
                    si.rdt <= sub_data(si.adr);
                    si.err <= sub_fault(si.adr);
                end else begin
                    si.rdt <= $urandom;
                    si.err <= 1'($urandom_range(0, 1));
                end
            end
        end

        req_ent_t req_q[$];
        rsp_ent_t rsp_q[$];
        req_t     hold_r;
        bit       hold = 1'b0;

        always @(negedge clk) begin
            req_ent_t qe;
            rsp_ent_t re;
            req_t     cur;
            cur = {si.wen, si.adr, si.ben, si.wdt};
            if (!rst) begin
                req_q.delete();
                rsp_q.delete();
                hold = 1'b0;
            end else begin
                if (mi.vld && mi.rdy) begin
                    qe.r   = {m_wen, m_adr, m_ben, m_wdt};
                    qe.lat = lat_chk;
                    qe.cyc = cyc + 1;
                    req_q.push_back(qe);
                    re.rdt = e_rdt;
                    re.err = e_err;
                    re.lat = lat_chk;
                    re.cyc = cyc + 1 + g;
                    rsp_q.push_back(re);
                end
                if (hold) begin
                    check_output($sformatf("lane%0d sub_vld held", g), si.vld, 1);
                    check_output($sformatf("lane%0d sub fields held", g), cur, hold_r);
                end
                hold   = si.vld && !si.rdy;
                hold_r = cur;
                if (si.vld && si.rdy) begin
                    check_output($sformatf("lane%0d sub transfer expected", g), req_q.size() != 0, 1);
                    if (req_q.size() != 0) begin
                        qe = req_q.pop_front();
                        check_output($sformatf("lane%0d sub request", g), cur, qe.r);
                        if (qe.lat) check_output($sformatf("lane%0d sub cycle", g), cyc, qe.cyc);
                    end
                end
                if (mi.rsp) begin
                    check_output($sformatf("lane%0d man_rsp expected", g), rsp_q.size() != 0, 1);
                    if (rsp_q.size() != 0) begin
                        re = rsp_q.pop_front();
                        check_output($sformatf("lane%0d man_rdt", g), mi.rdt, re.rdt);
                        check_output($sformatf("lane%0d man_err", g), mi.err, re.err);
                        if (re.lat) check_output($sformatf("lane%0d rsp cycle", g), cyc, re.cyc);
                    end
                end else begin
                    check_output($sformatf("lane%0d idle rdt/err", g), {mi.rdt, mi.err}, 0);
                end
            end
        end
    end

    task automatic apply_stimulus(input vec_t v, input bit chk_rdy);
        bit acc;
        acc   = 1'b0;
        m_vld = 1'b1;
        m_wen = v.wen;
        m_adr = v.adr;
        m_ben = v.ben;
        m_wdt = v.wdt;
        e_rdt = v.rdt;
        e_err = v.err;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            acc = lane[1].mi.rdy;
            if (chk_rdy) check_output("man_rdy streaming", lane[1].mi.rdy, 1);
            @(posedge clk);
            #1;
            if (acc) break;
        end
        check_output("request accepted", acc, 1);
    endtask

    task automatic set_read(input int k);
        m_vld = 1'b1;
        m_wen = 1'b0;
        m_adr = 32'h40 + 32'(4 * k);
        m_ben = 4'hF;
        m_wdt = '0;
        e_rdt = 32'h5A5A0040 + 32'(4 * k);
        e_err = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        m_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag, input logic rdy, input logic vld,
                                     input req_t f, input logic rsp, input logic [31:0] rdt,
                                     input logic err);
        check_output({tag, " man_rdy"}, rdy, 1);
        check_output({tag, " sub_vld"}, vld, 0);
        check_output({tag, " sub fields"}, f, 0);
        check_output({tag, " rsp/rdt/err"}, {rsp, rdt, err}, 0);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        logic [0:8] pat;
        logic [0:8] exp_rdy;
        int k;
        int n0;
        int n1;
        bit acc;

        vecs[0] = '{1'b1, 32'h00, 4'hF, 32'h11111111, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 32'h04, 4'hF, 32'h22222222, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 32'h08, 4'hF, 32'h33333333, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 32'h0C, 4'hF, 32'h44444444, 32'h0,        1'b0};
        vecs[4] = '{1'b0, 32'h20, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b0, 32'h04, 4'hF, 32'h0,        32'h12345678, 1'b0};
        vecs[6] = '{1'b0, 32'h30, 4'hF, 32'h0,        32'h5A5A0030, 1'b0};
        vecs[7] = '{1'b0, 32'h10, 4'hF, 32'h0,        32'h5A5A0010, 1'b1};
        vecs[8] = '{1'b0, 32'h14, 4'hF, 32'h0,        32'h5A5A0014, 1'b0};
        vecs[9] = '{1'b1, 32'h10, 4'h3, 32'hCAFE0000, 32'h0,        1'b1};

        pat = 9'b110001111;
`ifdef TCB_LIB_REGISTER_REQUEST_SKID_EN
        exp_rdy = 9'b111000111;
`else
        exp_rdy = 9'b110001111;
`endif

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("lane0 reset", lane[0].mi.rdy, lane[0].si.vld,
                          {lane[0].si.wen, lane[0].si.adr, lane[0].si.ben, lane[0].si.wdt},
                          lane[0].mi.rsp, lane[0].mi.rdt, lane[0].mi.err);
        check_reset_state("lane1 reset", lane[1].mi.rdy, lane[1].si.vld,
                          {lane[1].si.wen, lane[1].si.adr, lane[1].si.ben, lane[1].si.wdt},
                          lane[1].mi.rsp, lane[1].mi.rdt, lane[1].mi.err);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back table with sub_rdy high");
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) apply_stimulus(vecs[i], 1'b1);
        idle_cycles(6);
        check_output("lane0 drained after table", lane[0].rsp_q.size() + lane[0].req_q.size(), 0);
        check_output("lane1 drained after table", lane[1].rsp_q.size() + lane[1].req_q.size(), 0);

        $display("[TB] streaming reads with a three-cycle subordinate stall");
        lat_chk = 1'b0;
        k = 0;
        for (int j = 0; j < 9; j++) begin
            s_rdy = pat[j];
            set_read(k);
            @(negedge clk);
            acc = lane[1].mi.rdy;
            check_output($sformatf("stall man_rdy cycle %0d", j), lane[1].mi.rdy, exp_rdy[j]);
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        s_rdy = 1'b1;
        idle_cycles(8);
        check_output("lane0 drained after stall", lane[0].rsp_q.size() + lane[0].req_q.size(), 0);
        check_output("lane1 drained after stall", lane[1].rsp_q.size() + lane[1].req_q.size(), 0);

        $display("[TB] reset with responses in flight");
        for (int j = 0; j < 3; j++) begin
            set_read(16 + j);
            @(posedge clk);
            #1;
        end
        check_output("lane0 rsp before reset", lane[0].mi.rsp, 1);
        check_output("lane1 rsp before reset", lane[1].mi.rsp, 1);
        rst   = 1'b0;
        m_vld = 1'b0;
        #1;
        check_output("lane0 reset vld/rsp", {lane[0].si.vld, lane[0].mi.rsp}, 0);
        check_output("lane1 reset vld/rsp", {lane[1].si.vld, lane[1].mi.rsp}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_output("lane0 man_rdy after release", lane[0].mi.rdy, 1);
        check_output("lane1 man_rdy after release", lane[1].mi.rdy, 1);
        n0 = 0;
        n1 = 0;
        repeat (10) begin
            @(negedge clk);
            n0 += int'(lane[0].mi.rsp);
            n1 += int'(lane[1].mi.rsp);
        end
        check_output("lane0 stale rsp count", n0, 0);
        check_output("lane1 stale rsp count", n1, 0);
        @(posedge clk);
        #1;

        $display("[TB] reads after reset");
        lat_chk = 1'b1;
        for (int i = 4; i < 9; i++) apply_stimulus(vecs[i], 1'b1);
        idle_cycles(6);
        check_output("lane0 drained at end", lane[0].rsp_q.size() + lane[0].req_q.size(), 0);
        check_output("lane1 drained at end", lane[1].rsp_q.size() + lane[1].req_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
